// File: rtl/seg7_pkg.sv
// Shared types and constants for the four-digit seven-segment scan driver.
// Glyphs are active-low and ordered {g,f,e,d,c,b,a}.
package seg7_pkg;

    typedef logic [1:0] slot_t;

    localparam logic [6:0] SEG_OFF = 7'b1111111;
    localparam logic [3:0] AN_OFF  = 4'b1111;

    localparam logic [6:0] GLYPH_0 = 7'h40;
    localparam logic [6:0] GLYPH_1 = 7'h79;
    localparam logic [6:0] GLYPH_2 = 7'h24;
    localparam logic [6:0] GLYPH_3 = 7'h30;
    localparam logic [6:0] GLYPH_4 = 7'h19;
    localparam logic [6:0] GLYPH_5 = 7'h12;
    localparam logic [6:0] GLYPH_6 = 7'h02;
    localparam logic [6:0] GLYPH_7 = 7'h78;
    localparam logic [6:0] GLYPH_8 = 7'h00;
    localparam logic [6:0] GLYPH_9 = 7'h10;
    localparam logic [6:0] GLYPH_A = 7'h08;
    localparam logic [6:0] GLYPH_B = 7'h03;
    localparam logic [6:0] GLYPH_C = 7'h46;
    localparam logic [6:0] GLYPH_D = 7'h21;
    localparam logic [6:0] GLYPH_E = 7'h06;
    localparam logic [6:0] GLYPH_F = 7'h0E;

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex digit to active-low seven-segment glyph lookup.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] value,
    output logic [6:0] seg
);

    // Full hex lookup; 10-15 render as A, b, C, d, E, F.
    always_comb begin
        seg = SEG_OFF;
        case (value)
            4'h0: seg = GLYPH_0;
            4'h1: seg = GLYPH_1;
            4'h2: seg = GLYPH_2;
            4'h3: seg = GLYPH_3;
            4'h4: seg = GLYPH_4;
            4'h5: seg = GLYPH_5;
            4'h6: seg = GLYPH_6;
            4'h7: seg = GLYPH_7;
            4'h8: seg = GLYPH_8;
            4'h9: seg = GLYPH_9;
            4'hA: seg = GLYPH_A;
            4'hB: seg = GLYPH_B;
            4'hC: seg = GLYPH_C;
            4'hD: seg = GLYPH_D;
            4'hE: seg = GLYPH_E;
            4'hF: seg = GLYPH_F;
            default: seg = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Four-digit multiplexed seven-segment scan driver with per-frame input
// snapshot, dead time at every digit change and fully registered outputs.
// Optional feature macro: SEG7_LEADING_ZERO_BLANK_EN (leading-zero blanking).
// There is no handshake: D1..D4 are only sampled at the snapshot instant
// (pcnt==0 and slot==0); changes at any other time are ignored until then.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 16
) (
    input  logic       CLK,
    input  logic       CLR,
    input  logic [3:0] D1,
    input  logic [3:0] D2,
    input  logic [3:0] D3,
    input  logic [3:0] D4,
    output logic [6:0] SEG,
    output logic [3:0] AN,
    output logic       FRAME
);

    localparam int            PW        = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PCNT_LAST = PW'(SCAN_DIV - 1);
    localparam logic [PW-1:0] BLANK_END = PW'(BLANK_CYC);

    logic [PW-1:0] pcnt;
    slot_t         slot;
    logic [3:0]    snap [0:3];

    logic          snap_now;
    logic [3:0]    cur [0:3];
    logic [3:0]    digit;
    logic [6:0]    glyph;
    logic          in_dead;
    logic          lead_blank;
    logic [6:0]    seg_next;
    logic [3:0]    an_next;

    assign snap_now = (pcnt == '0) && (slot == 2'd0);
    assign in_dead  = (BLANK_CYC != 0) && (pcnt < BLANK_END);

    // Digit set seen this cycle: live inputs on the snapshot cycle (they are
    // being captured at this edge), the frozen snapshot otherwise.
    always_comb begin
        cur = snap;
        if (snap_now) begin
            cur[0] = D1;
            cur[1] = D2;
            cur[2] = D3;
            cur[3] = D4;
        end
    end

    assign digit = cur[slot];

    seg7_decode u_decode (
        .value (digit),
        .seg   (glyph)
    );

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    // A digit is dark when it and every digit to its left are zero; D4 always shows.
    always_comb begin
        lead_blank = 1'b0;
        case (slot)
            2'd0:    lead_blank = (cur[0] == 4'd0);
            2'd1:    lead_blank = (cur[0] == 4'd0) && (cur[1] == 4'd0);
            2'd2:    lead_blank = (cur[0] == 4'd0) && (cur[1] == 4'd0) && (cur[2] == 4'd0);
            default: lead_blank = 1'b0;
        endcase
    end
`else
    assign lead_blank = 1'b0;
`endif

    // Next output values: all off during dead time or blanking, else the slot's digit.
    always_comb begin
        seg_next = SEG_OFF;
        an_next  = AN_OFF;
        if (!in_dead && !lead_blank) begin
            seg_next = glyph;
            an_next  = AN_OFF & ~(4'b1000 >> slot);
        end
    end

    // Prescaler and slot counter; slot wraps naturally at 2 bits.
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            pcnt <= '0;
            slot <= 2'd0;
        end else if (pcnt == PCNT_LAST) begin
            pcnt <= '0;
            slot <= slot + 2'd1;
        end else begin
            pcnt <= pcnt + PW'(1);
        end
    end

    // Frame snapshot of the four digit inputs.
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            for (int i = 0; i < 4; i++) snap[i] <= 4'd0;
        end else if (snap_now) begin
            snap[0] <= D1;
            snap[1] <= D2;
            snap[2] <= D3;
            snap[3] <= D4;
        end
    end

    // Registered outputs; FRAME follows the snapshot cycle by one edge.
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            SEG   <= SEG_OFF;
            AN    <= AN_OFF;
            FRAME <= 1'b0;
        end else begin
            SEG   <= seg_next;
            AN    <= an_next;
            FRAME <= snap_now;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver (SCAN_DIV=8, BLANK_CYC=2).
// Honours SEG7_LEADING_ZERO_BLANK_EN in the same way as the design.
module tb_seg7_scan_driver;

    localparam int SCAN_DIV  = 8;
    localparam int BLANK_CYC = 2;
    localparam int FRAME_CYC = 4 * SCAN_DIV;

    logic       CLK;
    logic       CLR;
    logic [3:0] D1, D2, D3, D4;
    logic [6:0] SEG;
    logic [3:0] AN;
    logic       FRAME;

    int checks;
    int errors;
    int cyc;

    logic [6:0] glyph_tab [16];
    logic [3:0] an_tab [4];
    logic [3:0] snap_m [4];
    logic [6:0] exp_q [$];

    typedef struct {
        logic [3:0] d [4];
        logic [6:0] seg [4];
    } vec_t;

    vec_t vecs [4];

    seg7_scan_driver #(
        .SCAN_DIV  (SCAN_DIV),
        .BLANK_CYC (BLANK_CYC)
    ) dut (
        .CLK   (CLK),
        .CLR   (CLR),
        .D1    (D1),
        .D2    (D2),
        .D3    (D3),
        .D4    (D4),
        .SEG   (SEG),
        .AN    (AN),
        .FRAME (FRAME)
    );

    // Clock / reset block
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h cyc=%0d t=%0t", name, act, exp, cyc, $time);
        end
    endtask

    task automatic set_d(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c, input logic [3:0] d);
        D1 = a; D2 = b; D3 = c; D4 = d;
    endtask

    // Reset: outputs must go off at once and stay off while CLR is held.
    task automatic reset_dut();
        CLR = 1'b1;
        #1;
        check("rst_seg_async", {25'd0, SEG}, 32'h7F);
        check("rst_an_async", {28'd0, AN}, 32'hF);
        check("rst_frame_async", {31'd0, FRAME}, 32'd0);
        repeat (2) begin
            @(posedge CLK); #1;
            check("rst_seg_hold", {25'd0, SEG}, 32'h7F);
            check("rst_an_hold", {28'd0, AN}, 32'hF);
            check("rst_frame_hold", {31'd0, FRAME}, 32'd0);
        end
        CLR = 1'b0;
        cyc = 0;
    endtask

    // One clock with the reference model: time since release decides the slot,
    // the phase within the slot and whether this edge captures a new frame.
    task automatic tick();
        int ph, sl, pc;
        bit dark;
        logic [6:0] es;
        logic [3:0] ea;
        logic ef;
        ph = cyc % FRAME_CYC;
        if (ph == 0) begin
            snap_m[0] = D1; snap_m[1] = D2; snap_m[2] = D3; snap_m[3] = D4;
        end
        sl = ph / SCAN_DIV;
        pc = ph % SCAN_DIV;
        dark = (pc < BLANK_CYC);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        if (sl < 3) begin
            bit all_zero;
            all_zero = 1'b1;
            for (int k = 0; k <= sl; k++) if (snap_m[k] != 4'd0) all_zero = 1'b0;
            if (all_zero) dark = 1'b1;
        end
`endif
        es = dark ? 7'h7F : glyph_tab[snap_m[sl]];
        ea = dark ? 4'hF : an_tab[sl];
        ef = (ph == 0);
        @(posedge CLK); #1;
        check("model_seg", {25'd0, SEG}, {25'd0, es});
        check("model_an", {28'd0, AN}, {28'd0, ea});
        check("model_frame", {31'd0, FRAME}, {31'd0, ef});
        cyc++;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        cyc = 0;
        CLR = 1'b1;
        set_d(4'd1, 4'd2, 4'd3, 4'd4);

        glyph_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        an_tab = '{4'h7, 4'hB, 4'hD, 4'hE};

        vecs[0].d = '{4'd1, 4'd2, 4'd3, 4'd4};
        vecs[0].seg = '{7'h79, 7'h24, 7'h30, 7'h19};
        vecs[1].d = '{4'hA, 4'hB, 4'hC, 4'hF};
        vecs[1].seg = '{7'h08, 7'h03, 7'h46, 7'h0E};
        vecs[2].d = '{4'd0, 4'd0, 4'd0, 4'd7};
        vecs[3].d = '{4'd0, 4'd0, 4'd0, 4'd0};
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        vecs[2].seg = '{7'h7F, 7'h7F, 7'h7F, 7'h78};
        vecs[3].seg = '{7'h7F, 7'h7F, 7'h7F, 7'h40};
`else
        vecs[2].seg = '{7'h40, 7'h40, 7'h40, 7'h78};
        vecs[3].seg = '{7'h40, 7'h40, 7'h40, 7'h40};
`endif

        @(posedge CLK); #1;

        // Table-driven frames: mid-slot SEG per slot against the table.
        for (int v = 0; v < 4; v++) begin
            set_d(vecs[v].d[0], vecs[v].d[1], vecs[v].d[2], vecs[v].d[3]);
            reset_dut();
            for (int s = 0; s < 4; s++) exp_q.push_back(vecs[v].seg[s]);
            for (int n = 0; n < FRAME_CYC + 1; n++) begin
                int c;
                c = cyc;
                tick();
                if ((c % SCAN_DIV) == 5 && c < FRAME_CYC) begin
                    logic [6:0] e;
                    e = exp_q.pop_front();
                    check("vec_seg", {25'd0, SEG}, {25'd0, e});
                end
            end
        end

        // Snapshot coherence: D3 changes during slot 1 of the first frame.
        set_d(4'd1, 4'd2, 4'd3, 4'd4);
        reset_dut();
        for (int n = 0; n < 2 * FRAME_CYC; n++) begin
            int c;
            c = cyc;
            if (c == 10) D3 = 4'd9;
            tick();
            if (c == 21) check("coh_old", {25'd0, SEG}, 32'h30);
            if (c == 53) check("coh_new", {25'd0, SEG}, 32'h10);
            if (c == 32) check("frame_period", {31'd0, FRAME}, 32'd1);
        end

        // Reset mid-slot 2: outputs must drop before the next edge.
        while (cyc % FRAME_CYC != 20) tick();
        check("pre_rst_an", {28'd0, AN}, 32'hD);
        CLR = 1'b1;
        #1;
        check("mid_rst_seg", {25'd0, SEG}, 32'h7F);
        check("mid_rst_an", {28'd0, AN}, 32'hF);
        check("mid_rst_frame", {31'd0, FRAME}, 32'd0);
        reset_dut();
        for (int n = 0; n < FRAME_CYC; n++) tick();

        // Randomized digits, changing at arbitrary cycles including snapshot edges.
        set_d(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
              4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        reset_dut();
        for (int n = 0; n < 6 * FRAME_CYC; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                case ($urandom_range(0, 3))
                    0: D1 = 4'($urandom_range(0, 15));
                    1: D2 = 4'($urandom_range(0, 15));
                    2: D3 = 4'($urandom_range(0, 15));
                    default: D4 = 4'($urandom_range(0, 15));
                endcase
            end
            if ($urandom_range(0, 7) == 0) set_d(4'd0, 4'd0, 4'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
